memory_stage: RTL and testbench

- MEM stage of the pipelined scalar/vector processor. It sits between the EX/MEM and MEM/WB boundaries.
- Performs data-memory and memory-mapped I/O reads and writes.
- Registers the read data plus all write-back control fields into one 302-bit pipeline buffer (bufferOut) for the write-back stage.

---
 rtl/memory_stage.sv | 90 +++++++++
 tb/tb_memory_stage.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// MEM stage: data RAM plus memory-mapped I/O, results registered into the MEM/WB buffer.
// Latency 1 cycle for every field; no handshake, en=0 stalls (holds buffer, blocks writes).
module memory_stage #(
  parameter int DEPTH    = 8192,
  parameter int IO_SPACE = 76
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [1:0]   opType,
  input  logic [3:0]   opCode,
  input  logic [143:0] address1,
  input  logic [23:0]  address2,
  input  logic         memWrite,
  input  logic         memToReg,
  input  logic         regWrite,
  input  logic         regWriteV,
  input  logic         modeSel,
  input  logic [3:0]   Rc,
  input  logic [143:0] writeData,
  input  logic [3:0]   switches,
  input  logic [35:0]  gpio1,
  output logic [35:0]  gpio2,
  output logic [15:0]  q,
  output logic [301:0] bufferOut
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [143:0] mem [DEPTH];

  logic [301:0] buffer_d, buffer_q;
  logic [35:0]  gpio2_d, gpio2_q;
  logic [23:0]  scal_a, ram_idx;
  logic         is_io, ram_ok, ram_we;
  logic [143:0] rd_data;

  always_comb begin
    scal_a  = address1[23:0];
    is_io   = !modeSel && (scal_a < 24'(IO_SPACE));
    // Vector addresses arrive already offset-adjusted; scalar ones are rebased here.
    ram_idx = modeSel ? address2 : (scal_a - 24'(IO_SPACE));
    ram_ok  = !is_io && (ram_idx < 24'(DEPTH));
    ram_we  = en && memWrite && ram_ok && !rst;

    rd_data = '0;
    if (ram_ok) begin
      rd_data = mem[ram_idx[IW-1:0]];
    end else if (is_io) begin
      case (scal_a)
        24'd36:  rd_data = 144'(switches);
        24'd37:  rd_data = 144'(gpio1);
        24'd38:  rd_data = 144'(gpio2_q);
        default: rd_data = '0;
      endcase
    end

    gpio2_d = gpio2_q;
    if (en && memWrite && is_io && (scal_a == 24'd30)) begin
      gpio2_d = writeData[35:0];
    end

    buffer_d = buffer_q;
    if (en) begin
      buffer_d = {regWriteV, modeSel, opType, opCode, memToReg, regWrite, Rc, rd_data, address1};
    end
  end

  // RAM has no reset so it maps onto block RAM; the read above sees pre-write contents.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_idx[IW-1:0]] <= writeData;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buffer_q <= '0;
      gpio2_q  <= '0;
    end else begin
      buffer_q <= buffer_d;
      gpio2_q  <= gpio2_d;
    end
  end

  assign bufferOut = buffer_q;
  assign gpio2     = gpio2_q;
  assign q         = buffer_q[159:144];

endmodule

// File: tb/tb_memory_stage.sv
// Directed-vector bench for memory_stage with a queue scoreboard and a negedge monitor.
module tb_memory_stage;

  logic         clk = 1'b0;
  logic         rst, en;
  logic [1:0]   opType;
  logic [3:0]   opCode, Rc, switches;
  logic [143:0] address1, writeData;
  logic [23:0]  address2;
  logic         memWrite, memToReg, regWrite, regWriteV, modeSel;
  logic [35:0]  gpio1, gpio2;
  logic [15:0]  q;
  logic [301:0] bufferOut;

  always #5 clk = ~clk;

  memory_stage dut (
    .clk(clk), .rst(rst), .en(en), .opType(opType), .opCode(opCode),
    .address1(address1), .address2(address2), .memWrite(memWrite),
    .memToReg(memToReg), .regWrite(regWrite), .regWriteV(regWriteV),
    .modeSel(modeSel), .Rc(Rc), .writeData(writeData), .switches(switches),
    .gpio1(gpio1), .gpio2(gpio2), .q(q), .bufferOut(bufferOut)
  );

  typedef struct {
    string        nm;
    logic [301:0] exp;
    logic [301:0] msk;
    logic [35:0]  gexp;
    bit           gchk;
  } item_t;

  item_t sb[$];
  int n_vec = 0;
  int n_bad = 0;

  logic [301:0] FULL, NORD, last;

  function automatic logic [301:0] mk(int rwv, int ms, int ot, int oc, int m2r,
                                      int rw, int rc, int rd, int a1);
    return {1'(rwv), 1'(ms), 2'(ot), 4'(oc), 1'(m2r), 1'(rw), 4'(rc), 144'(rd), 144'(a1)};
  endfunction

  task automatic clr();
    opType = '0; opCode = '0; Rc = '0; address1 = '0; address2 = '0;
    writeData = '0; memWrite = 1'b0; memToReg = 1'b0; regWrite = 1'b0;
    regWriteV = 1'b0; modeSel = 1'b0;
  endtask

  // Inputs are set at a negedge; the edge then launches one expected response.
  task automatic tick(string nm, logic [301:0] e, logic [301:0] m, logic [35:0] g, bit gc);
    item_t it;
    @(posedge clk);
    it.nm = nm; it.exp = e; it.msk = m; it.gexp = g; it.gchk = gc;
    sb.push_back(it);
    @(negedge clk);
  endtask

  initial begin : monitor
    item_t it;
    bit bad;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        it = sb.pop_front();
        n_vec++;
        bad = 1'b0;
        if ((bufferOut & it.msk) !== (it.exp & it.msk)) bad = 1'b1;
        if (it.msk[144] && (q !== it.exp[159:144])) bad = 1'b1;
        if (it.gchk && (gpio2 !== it.gexp)) bad = 1'b1;
        if (bad) begin
          n_bad++;
          $display("FAIL %s: got bufferOut=%h q=%h gpio2=%h, want bufferOut=%h (mask %h) q=%h gpio2=%h",
                   it.nm, bufferOut, q, gpio2, it.exp, it.msk, it.exp[159:144], it.gexp);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    item_t it;
    FULL = '1;
    NORD = '1;
    NORD[287:144] = '0;

    rst = 1'b1; en = 1'b1; clr();
    address1 = 144'($urandom); writeData = 144'($urandom); memWrite = 1'b1;
    regWrite = 1'b1; Rc = 4'($urandom); opCode = 4'($urandom);
    switches = 4'($urandom); gpio1 = 36'($urandom);
    @(negedge clk);
    tick("reset", '0, FULL, 36'd0, 1'b1);
    address1 = 144'd30; writeData = 144'd3;
    tick("reset_hold", '0, FULL, 36'd0, 1'b1);

    rst = 1'b0; clr();
    address1 = 144'd500; Rc = 4'd12; regWrite = 1'b1; memToReg = 1'b1; opCode = 4'd9;
    opType = 2'd3; modeSel = 1'b1; regWriteV = 1'b1; address2 = 24'd9000;
    tick("passthru", mk(1, 1, 3, 9, 1, 1, 12, 0, 500), FULL, 36'd0, 1'b1);

    clr(); address1 = 144'd5000; writeData = 144'd255; memWrite = 1'b1;
    tick("wr5000", mk(0, 0, 0, 0, 0, 0, 0, 0, 5000), NORD, 36'd0, 1'b0);
    clr(); address1 = 144'd5000;
    tick("rd5000", mk(0, 0, 0, 0, 0, 0, 0, 255, 5000), FULL, 36'd0, 1'b0);

    clr(); address1 = 144'd6000; writeData = 144'hAA; memWrite = 1'b1;
    tick("wr6000", mk(0, 0, 0, 0, 0, 0, 0, 0, 6000), NORD, 36'd0, 1'b0);
    writeData = 144'hBB;
    tick("rdw_old", mk(0, 0, 0, 0, 0, 0, 0, 'hAA, 6000), FULL, 36'd0, 1'b0);
    clr(); address1 = 144'd6000;
    tick("rd6000_new", mk(0, 0, 0, 0, 0, 0, 0, 'hBB, 6000), FULL, 36'd0, 1'b0);

    clr(); address1 = 144'd30; writeData = 144'd1; memWrite = 1'b1;
    tick("gpio_wr", mk(0, 0, 0, 0, 0, 0, 0, 0, 30), FULL, 36'd1, 1'b1);
    clr(); address1 = 144'd38;
    tick("gpio_rb", mk(0, 0, 0, 0, 0, 0, 0, 1, 38), FULL, 36'd1, 1'b1);
    switches = 4'b1101; address1 = 144'd36;
    tick("switches", mk(0, 0, 0, 0, 0, 0, 0, 13, 36), FULL, 36'd1, 1'b1);
    gpio1 = 36'd23; address1 = 144'd37;
    tick("gpio1", mk(0, 0, 0, 0, 0, 0, 0, 23, 37), FULL, 36'd1, 1'b1);

    clr(); modeSel = 1'b1; address2 = 24'd4924;
    tick("vec_rd", mk(0, 1, 0, 0, 0, 0, 0, 255, 0), FULL, 36'd1, 1'b1);

    clr(); address1 = 144'd75;
    tick("io_unmapped", mk(0, 0, 0, 0, 0, 0, 0, 0, 75), FULL, 36'd1, 1'b0);
    address1 = 144'd76; writeData = 144'h55; memWrite = 1'b1;
    tick("wr76", mk(0, 0, 0, 0, 0, 0, 0, 0, 76), NORD, 36'd1, 1'b0);
    clr(); address1 = 144'd76;
    tick("rd76", mk(0, 0, 0, 0, 0, 0, 0, 'h55, 76), FULL, 36'd1, 1'b0);
    address1 = 144'd8267; writeData = 144'h77; memWrite = 1'b1;
    tick("wr_top", mk(0, 0, 0, 0, 0, 0, 0, 0, 8267), NORD, 36'd1, 1'b0);
    clr(); address1 = 144'd8267;
    tick("rd_top", mk(0, 0, 0, 0, 0, 0, 0, 'h77, 8267), FULL, 36'd1, 1'b0);
    address1 = 144'd8268; writeData = 144'h99; memWrite = 1'b1;
    tick("wr_oob", mk(0, 0, 0, 0, 0, 0, 0, 0, 8268), FULL, 36'd1, 1'b1);
    clr(); address1 = 144'd76;
    tick("rd76_after_oob", mk(0, 0, 0, 0, 0, 0, 0, 'h55, 76), FULL, 36'd1, 1'b0);

    clr(); modeSel = 1'b1; address2 = 24'd100; writeData = 144'h66; memWrite = 1'b1;
    tick("vec_wr", mk(0, 1, 0, 0, 0, 0, 0, 0, 0), NORD, 36'd1, 1'b0);
    clr(); address1 = 144'd176;
    tick("scal_rd_vec", mk(0, 0, 0, 0, 0, 0, 0, 'h66, 176), FULL, 36'd1, 1'b0);

    clr(); address1 = 144'd5000;
    last = mk(0, 0, 0, 0, 0, 0, 0, 255, 5000);
    tick("rd5000_pre", last, FULL, 36'd1, 1'b1);
    en = 1'b0; memWrite = 1'b1; writeData = 144'd7; Rc = 4'd5; regWrite = 1'b1;
    tick("stall_ram", last, FULL, 36'd1, 1'b1);
    address1 = 144'd30; writeData = 144'd5;
    tick("stall_gpio", last, FULL, 36'd1, 1'b1);
    en = 1'b1; clr(); address1 = 144'd5000;
    tick("rd5000_post", last, FULL, 36'd1, 1'b1);

    en = 1'b0; address1 = 144'd30; writeData = 144'd9; memWrite = 1'b1;
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    it.nm = "rst_async"; it.exp = '0; it.msk = FULL; it.gexp = 36'd0; it.gchk = 1'b1;
    sb.push_back(it);
    @(negedge clk);
    tick("rst_stall_hold", '0, FULL, 36'd0, 1'b1);
    en = 1'b1; clr(); address1 = 144'd5000;
    tick("ram_kept", mk(0, 0, 0, 0, 0, 0, 0, 255, 5000), FULL, 36'd0, 1'b1);
    address1 = 144'd38;
    tick("gpio_cleared", mk(0, 0, 0, 0, 0, 0, 0, 0, 38), FULL, 36'd0, 1'b1);

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d responses left unchecked, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
